debounce_sync: RTL

Synchronizer and debouncer for the active-high level produced by the `inverter` stage. The `inverter` converts an active-low pushbutton or switch into an active-high level, and this block consumes that level. It takes the asynchronous `in` through a 2-flop synchronizer and accepts a new level only after it has been stable for `STABLE_CYCLES` clocks. It drives a clean level, optional one-cycle edge pulses and a wrapping press counter to downstream logic.

---
 rtl/debounce_sync.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchronizer plus level debouncer for the active-high
// level coming from the inverter stage. A new level is accepted only after
// STABLE_CYCLES consecutive synchronized samples agree; any bounce back to the
// old level restarts qualification from zero.
//
// Optional feature macro: DEBOUNCE_PULSE_EN
//   defined   -> registered one-cycle rise/fall pulses on each accepted edge
//   undefined -> rise/fall tied to 0, pulse registers removed; out, press_cnt
//                and all timing are identical in both builds.

module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       out,
  output logic       rise,
  output logic       fall,
  output logic [7:0] press_cnt
);

  localparam int unsigned PRESS_W = 8;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  // Synchronizer flops; only s2 is allowed to influence the FSM.
  logic s1;
  logic s2;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             out_d;
  logic             accept_rise;
  logic             accept_fall;

  // Two-stage synchronizer for the asynchronous input level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  // FSM state, stability counter and debounced level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE_LOW;
      cnt   <= CNT_ZERO;
      out   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      out   <= out_d;
    end
  end

  // Next-state logic: qualify a level change over STABLE_CYCLES samples of s2.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    out_d       = out;
    accept_rise = 1'b0;
    accept_fall = 1'b0;

    case (state)
      STABLE_LOW: begin
        out_d = 1'b0;
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end

      WAIT_HIGH: begin
        out_d = 1'b0;
        if (!s2) begin
          // Bounced back low: abandon qualification, no partial credit.
          state_d = STABLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_d     = STABLE_HIGH;
          cnt_d       = CNT_ZERO;
          out_d       = 1'b1;
          accept_rise = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      STABLE_HIGH: begin
        out_d = 1'b1;
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end

      WAIT_LOW: begin
        out_d = 1'b1;
        if (s2) begin
          // Bounced back high: abandon qualification.
          state_d = STABLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_d     = STABLE_LOW;
          cnt_d       = CNT_ZERO;
          out_d       = 1'b0;
          accept_fall = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      default: begin
        state_d = STABLE_LOW;
        cnt_d   = CNT_ZERO;
        out_d   = 1'b0;
      end
    endcase
  end

  // Wrapping count of accepted 0->1 transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= '0;
    end else if (accept_rise) begin
      press_cnt <= press_cnt + PRESS_W'(1);
    end
  end

`ifdef DEBOUNCE_PULSE_EN
  // Registered one-cycle edge pulses; accept_rise/accept_fall are exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept_rise;
      fall <= accept_fall;
    end
  end
`else
  // Pulse outputs disabled: constant low, no registers.
  logic pulse_unused;
  assign pulse_unused = accept_fall;
  assign rise         = 1'b0;
  assign fall         = 1'b0;
`endif

endmodule
